// File: rtl/obstacle_pkg.sv
// obstacle_pkg: shared types and helpers for the obstacle lane generator.
//   coord_t  : signed screen coordinate, one bit wider than the default lane
//              coordinate so that sums of position and width never wrap.
//   state_t  : lane controller states (INIT sweep, RUN).
//   wrap_add : circular add/subtract of a step on [0, span).
package obstacle_pkg;

   localparam int COORD_W_PKG = 11;
   localparam int WRAP_W      = 16;

   typedef logic signed [COORD_W_PKG:0] coord_t;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   // x is in [0, span) and step < span, so a single correction always lands
   // back in range in either direction.
   function automatic logic [WRAP_W-1:0] wrap_add(
      input logic [WRAP_W-1:0] x,
      input logic [WRAP_W-1:0] step,
      input logic              dir,
      input logic [WRAP_W-1:0] span
   );
      logic [WRAP_W-1:0] r;
      if (dir) begin
         r = x + step;
         if (r >= span) r = r - span;
      end else begin
         if (x < step) r = x + span - step;
         else          r = x - step;
      end
      return r;
   endfunction

endpackage

// File: rtl/obstacle_hit.sv
// obstacle_hit: combinational box-overlap test between the frog and one
// lane object. Horizontal overlap is strict, so boxes that only share an
// edge do not hit. Vertical test is an exact lane match.
//   valid_i  : object is enabled and in range
//   obj_x_i  : object left edge, two's complement
//   row_y_i  : lane top
//   frog_x_i : frog left edge (on-screen, unsigned)
//   frog_y_i : frog top
//   hit_o    : frog overlaps this object
module obstacle_hit #(
   parameter int COORD_W = 11,
   parameter int OBJ_W   = 40,
   parameter int FROG_W  = 40
) (
   input  logic               valid_i,
   input  logic [COORD_W-1:0] obj_x_i,
   input  logic [COORD_W-1:0] row_y_i,
   input  logic [COORD_W-1:0] frog_x_i,
   input  logic [COORD_W-1:0] frog_y_i,
   output logic               hit_o
);

   localparam logic signed [COORD_W:0] OBJ_W_S  = (COORD_W+1)'(OBJ_W);
   localparam logic signed [COORD_W:0] FROG_W_S = (COORD_W+1)'(FROG_W);

   logic signed [COORD_W:0] ox;
   logic signed [COORD_W:0] fx;

   // Object x may sit left of the screen (down to -OBJ_W), so sign-extend it.
   assign ox = {obj_x_i[COORD_W-1], obj_x_i};
   assign fx = {1'b0, frog_x_i};

   assign hit_o = valid_i
                && (frog_y_i == row_y_i)
                && (fx < ox + OBJ_W_S)
                && (fx + FROG_W_S > ox);

endmodule

// File: rtl/obstacle_row_gen.sv
// obstacle_row_gen: one lane of horizontally scrolling objects (cars or
// lilypads). Objects are laid out by an init sweep, then scroll with a
// fractional speed and wrap around a span of SCREEN_W + OBJ_W.
//   frame_clk / Reset : frame clock, synchronous active-high reset
//   enable            : advance objects this frame
//   num_obj, obj_mask : which slots are visible / collidable
//   gap               : spacing used by the init sweep
//   speed, direction  : fixed-point pixels per frame, 1 = right
//   row_y             : lane top
//   frog_x, frog_y    : frog box position
//   ready             : high once the init sweep is done (RUN state)
//   obj_x, obj_y      : per-slot left edge (two's complement) and top
//   obj_valid         : per-slot visible flag
//   collide, coll_idx : frog overlap and lowest overlapping slot
//   carry_dx          : carrier mode only, signed displacement for the frog
//
// Valid/ready: there is no handshake; ready simply reports that positions
// are meaningful. Every input change shows on the next frame_clk edge.
module obstacle_row_gen
   import obstacle_pkg::*;
#(
   parameter int MAX_OBJ  = 8,
   parameter int COORD_W  = 11,
   parameter int SCREEN_W = 640,
   parameter int OBJ_W    = 40,
   parameter int FROG_W   = 40,
   parameter int SPEED_W  = 8,
   parameter int FRAC_W   = 4,
   parameter int MODE     = 0
) (
   input  logic                       frame_clk,
   input  logic                       Reset,
   input  logic                       enable,
   input  logic [3:0]                 num_obj,
   input  logic [7:0]                 gap,
   input  logic [SPEED_W-1:0]         speed,
   input  logic                       direction,
   input  logic [COORD_W-1:0]         row_y,
   input  logic [MAX_OBJ-1:0]         obj_mask,
   input  logic [COORD_W-1:0]         frog_x,
   input  logic [COORD_W-1:0]         frog_y,
   output logic                       ready,
   output logic [MAX_OBJ*COORD_W-1:0] obj_x,
   output logic [MAX_OBJ*COORD_W-1:0] obj_y,
   output logic [MAX_OBJ-1:0]         obj_valid,
   output logic                       collide,
   output logic [3:0]                 coll_idx,
   output logic [COORD_W-1:0]         carry_dx
);

   localparam int SPAN   = SCREEN_W + OBJ_W;
   localparam int STEP_W = SPEED_W + 1 - FRAC_W;

   state_t             state_q, state_d;
   logic [3:0]         idx_q, idx_d;
   logic [FRAC_W-1:0]  acc_q, acc_d;
   logic [COORD_W-1:0] next_pos_q, next_pos_d;
   logic [COORD_W-1:0] x_off_q [MAX_OBJ];
   logic [COORD_W-1:0] x_off_d [MAX_OBJ];
   logic [COORD_W-1:0] obj_x_q [MAX_OBJ];
   logic [COORD_W-1:0] obj_x_d [MAX_OBJ];
   logic               collide_q, collide_d;
   logic [3:0]         coll_idx_q, coll_idx_d;
   logic [COORD_W-1:0] carry_q, carry_d;

   logic [SPEED_W:0]   sum;
   logic [STEP_W-1:0]  step;
   logic [3:0]         num_eff;
   logic [MAX_OBJ-1:0] valid;
   logic [MAX_OBJ-1:0] hit;

   // Visibility follows num_obj/obj_mask combinationally; nothing is valid
   // until the sweep has placed every slot.
   always_comb begin
      num_eff = (num_obj > 4'(MAX_OBJ)) ? 4'(MAX_OBJ) : num_obj;
      valid   = '0;
      for (int i = 0; i < MAX_OBJ; i++) begin
         valid[i] = (state_q == RUN) && (4'(i) < num_eff) && obj_mask[i];
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      acc_d      = acc_q;
      next_pos_d = next_pos_q;
      x_off_d    = x_off_q;
      obj_x_d    = obj_x_q;
      sum        = (SPEED_W+1)'(speed) + (SPEED_W+1)'(acc_q);
      step       = '0;

      case (state_q)
         INIT: begin
            for (int i = 0; i < MAX_OBJ; i++) begin
               if (idx_q == 4'(i)) begin
                  x_off_d[i] = next_pos_q;
                  obj_x_d[i] = next_pos_q - COORD_W'(OBJ_W);
               end
            end
            next_pos_d = COORD_W'(wrap_add(WRAP_W'(next_pos_q),
                                           WRAP_W'(OBJ_W) + WRAP_W'(gap),
                                           1'b1, WRAP_W'(SPAN)));
            if (idx_q == 4'(MAX_OBJ - 1)) begin
               state_d = RUN;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 4'd1;
            end
         end
         RUN: begin
            if (enable) begin
               step  = sum[SPEED_W:FRAC_W];
               acc_d = sum[FRAC_W-1:0];
            end
            // Disabled slots keep moving so they reappear correctly spaced.
            for (int i = 0; i < MAX_OBJ; i++) begin
               x_off_d[i] = COORD_W'(wrap_add(WRAP_W'(x_off_q[i]), WRAP_W'(step),
                                              direction, WRAP_W'(SPAN)));
               obj_x_d[i] = x_off_d[i] - COORD_W'(OBJ_W);
            end
         end
         default: state_d = INIT;
      endcase
   end

   // Collision looks at the positions being written this edge, so the
   // registered flag lines up with the registered obj_x.
   for (genvar g = 0; g < MAX_OBJ; g++) begin : g_slot
      obstacle_hit #(
         .COORD_W (COORD_W),
         .OBJ_W   (OBJ_W),
         .FROG_W  (FROG_W)
      ) u_hit (
         .valid_i  (valid[g]),
         .obj_x_i  (obj_x_d[g]),
         .row_y_i  (row_y),
         .frog_x_i (frog_x),
         .frog_y_i (frog_y),
         .hit_o    (hit[g])
      );
      assign obj_x[g*COORD_W +: COORD_W] = obj_x_q[g];
      assign obj_y[g*COORD_W +: COORD_W] = row_y;
   end

   always_comb begin
      collide_d  = |hit;
      coll_idx_d = '0;
      for (int i = MAX_OBJ - 1; i >= 0; i--) begin
         if (hit[i]) coll_idx_d = 4'(i);
      end
      carry_d = '0;
      if (MODE == 1 && collide_d) begin
         carry_d = direction ? COORD_W'(step)
                             : {COORD_W{1'b0}} - COORD_W'(step);
      end
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state_q    <= INIT;
         idx_q      <= '0;
         acc_q      <= '0;
         next_pos_q <= COORD_W'(OBJ_W);
         collide_q  <= 1'b0;
         coll_idx_q <= '0;
         carry_q    <= '0;
         for (int i = 0; i < MAX_OBJ; i++) begin
            x_off_q[i] <= '0;
            obj_x_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         acc_q      <= acc_d;
         next_pos_q <= next_pos_d;
         collide_q  <= collide_d;
         coll_idx_q <= coll_idx_d;
         carry_q    <= carry_d;
         x_off_q    <= x_off_d;
         obj_x_q    <= obj_x_d;
      end
   end

   // ready is the state itself, so the FSM is directly observable.
   assign ready     = (state_q == RUN);
   assign obj_valid = valid;
   assign collide   = collide_q;
   assign coll_idx  = coll_idx_q;
   assign carry_dx  = carry_q;

endmodule

// File: tb/tb_obstacle_row_gen.sv
module tb_obstacle_row_gen;

   localparam int MAX_OBJ = 8;
   localparam int COORD_W = 11;
   localparam int OBJ_W   = 40;
   localparam int SPAN    = 680;
   localparam int FRAC_W  = 4;
   localparam int ROW     = 100;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                       Reset;
   logic                       enable;
   logic [3:0]                 num_obj;
   logic [7:0]                 gap;
   logic [7:0]                 speed;
   logic                       direction;
   logic [COORD_W-1:0]         row_y;
   logic [MAX_OBJ-1:0]         obj_mask;
   logic [COORD_W-1:0]         frog_x;
   logic [COORD_W-1:0]         frog_y;

   logic                       ready_h, ready_c;
   logic [MAX_OBJ*COORD_W-1:0] obj_x_h, obj_x_c, obj_y_h, obj_y_c;
   logic [MAX_OBJ-1:0]         obj_valid_h, obj_valid_c;
   logic                       collide_h, collide_c;
   logic [3:0]                 coll_idx_h, coll_idx_c;
   logic [COORD_W-1:0]         carry_h, carry_c;

   obstacle_row_gen #(.MODE(0)) dut_h (
      .frame_clk (clk),       .Reset     (Reset),     .enable   (enable),
      .num_obj   (num_obj),   .gap       (gap),       .speed    (speed),
      .direction (direction), .row_y     (row_y),     .obj_mask (obj_mask),
      .frog_x    (frog_x),    .frog_y    (frog_y),    .ready    (ready_h),
      .obj_x     (obj_x_h),   .obj_y     (obj_y_h),   .obj_valid(obj_valid_h),
      .collide   (collide_h), .coll_idx  (coll_idx_h),.carry_dx (carry_h)
   );

   obstacle_row_gen #(.MODE(1)) dut_c (
      .frame_clk (clk),       .Reset     (Reset),     .enable   (enable),
      .num_obj   (num_obj),   .gap       (gap),       .speed    (speed),
      .direction (direction), .row_y     (row_y),     .obj_mask (obj_mask),
      .frog_x    (frog_x),    .frog_y    (frog_y),    .ready    (ready_c),
      .obj_x     (obj_x_c),   .obj_y     (obj_y_c),   .obj_valid(obj_valid_c),
      .collide   (collide_c), .coll_idx  (coll_idx_c),.carry_dx (carry_c)
   );

   // scoreboard
   typedef struct packed {
      logic [MAX_OBJ*COORD_W-1:0] ox;
      logic [MAX_OBJ-1:0]         valid;
      logic                       collide;
      logic [3:0]                 idx;
      logic [COORD_W-1:0]         carry;
   } exp_t;
   localparam int EXP_W = $bits(exp_t);
   logic [EXP_W-1:0] exp_q[$];

   int n_vec = 0;
   int n_bad = 0;

   // reference model state: offsets in [0, SPAN) and the sub-pixel accumulator
   int mx [MAX_OBJ];
   int macc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [31:0] slot_of(input logic [MAX_OBJ*COORD_W-1:0] v, input int i);
      return 32'(v[i*COORD_W +: COORD_W]);
   endfunction

   task automatic chk_x(input string tag, input int slot, input int exp_x);
      chk(tag, slot_of(obj_x_h, slot), 32'(exp_x) & 32'h7FF);
   endtask

   // One RUN frame: model the edge, queue the expectation, clock, compare.
   task automatic run_frame(input string tag);
      exp_t e;
      int   st, sum, nv, ox, fx;
      logic v;
      st = 0;
      if (enable) begin
         sum  = macc + int'(speed);
         st   = sum / (1 << FRAC_W);
         macc = sum % (1 << FRAC_W);
      end
      for (int i = 0; i < MAX_OBJ; i++) begin
         if (direction) mx[i] = (mx[i] + st) % SPAN;
         else           mx[i] = (mx[i] - st + SPAN) % SPAN;
      end
      nv = (int'(num_obj) > MAX_OBJ) ? MAX_OBJ : int'(num_obj);
      fx = int'(frog_x);
      e  = '0;
      for (int i = 0; i < MAX_OBJ; i++) begin
         v = (i < nv) && obj_mask[i];
         e.valid[i] = v;
         e.ox[i*COORD_W +: COORD_W] = COORD_W'(mx[i] - OBJ_W);
         ox = mx[i] - OBJ_W;
         if (v && frog_y == row_y && fx < ox + 40 && fx + 40 > ox && !e.collide) begin
            e.collide = 1'b1;
            e.idx     = 4'(i);
         end
      end
      if (e.collide) e.carry = COORD_W'(direction ? st : -st);
      exp_q.push_back(e);

      @(posedge clk); #1;
      e = exp_q.pop_front();
      for (int i = 0; i < MAX_OBJ; i++) begin
         chk($sformatf("%s x_h%0d", tag, i), slot_of(obj_x_h, i), slot_of(e.ox, i));
         chk($sformatf("%s x_c%0d", tag, i), slot_of(obj_x_c, i), slot_of(e.ox, i));
         chk($sformatf("%s y_h%0d", tag, i), slot_of(obj_y_h, i), 32'(row_y));
         chk($sformatf("%s y_c%0d", tag, i), slot_of(obj_y_c, i), 32'(row_y));
      end
      chk({tag, " valid_h"}, 32'(obj_valid_h), 32'(e.valid));
      chk({tag, " valid_c"}, 32'(obj_valid_c), 32'(e.valid));
      chk({tag, " ready_h"}, 32'(ready_h), 32'd1);
      chk({tag, " ready_c"}, 32'(ready_c), 32'd1);
      chk({tag, " coll_h"},  32'(collide_h), 32'(e.collide));
      chk({tag, " coll_c"},  32'(collide_c), 32'(e.collide));
      chk({tag, " idx_h"},   32'(coll_idx_h), 32'(e.idx));
      chk({tag, " idx_c"},   32'(coll_idx_c), 32'(e.idx));
      chk({tag, " carry_h"}, 32'(carry_h), 32'd0);
      chk({tag, " carry_c"}, 32'(carry_c), 32'(e.carry));
   endtask

   // Reset edge, then the eight-cycle placement sweep.
   task automatic do_reset(input logic [7:0] g);
      int np;
      gap   = g;
      Reset = 1'b1;
      @(posedge clk); #1;
      Reset = 1'b0;
      chk("rst ready_h", 32'(ready_h), 32'd0);
      chk("rst ready_c", 32'(ready_c), 32'd0);
      chk("rst coll_h",  32'(collide_h), 32'd0);
      chk("rst coll_c",  32'(collide_c), 32'd0);
      chk("rst idx_h",   32'(coll_idx_h), 32'd0);
      chk("rst carry_c", 32'(carry_c), 32'd0);
      chk("rst x_h",     32'(|obj_x_h), 32'd0);
      chk("rst x_c",     32'(|obj_x_c), 32'd0);
      for (int k = 1; k <= MAX_OBJ; k++) begin
         @(posedge clk); #1;
         chk($sformatf("init%0d ready", k), 32'(ready_h), 32'(k == MAX_OBJ));
         chk($sformatf("init%0d coll", k),  32'(collide_h | collide_c), 32'd0);
         if (k < MAX_OBJ) chk($sformatf("init%0d valid", k), 32'(obj_valid_h), 32'd0);
      end
      np = OBJ_W;
      for (int k = 0; k < MAX_OBJ; k++) begin
         mx[k] = np;
         np = np + OBJ_W + int'(gap);
         if (np >= SPAN) np = np - SPAN;
      end
      macc = 0;
      for (int k = 0; k < MAX_OBJ; k++) begin
         chk($sformatf("init x%0d", k), slot_of(obj_x_h, k), 32'(mx[k] - OBJ_W) & 32'h7FF);
      end
   endtask

   initial begin
      Reset = 1'b1; enable = 1'b0; num_obj = 4'd4; gap = 8'd80; speed = 8'd0;
      direction = 1'b1; row_y = COORD_W'(ROW); obj_mask = 8'hFF;
      frog_x = '0; frog_y = '0;

      // layout after init with gap 80
      do_reset(8'd80);
      chk_x("lay0", 0, 0); chk_x("lay1", 1, 120); chk_x("lay2", 2, 240); chk_x("lay3", 3, 360);
      chk("lay valid", 32'(obj_valid_h), 32'h0F);

      // whole, half and one-and-a-half pixel speeds
      enable = 1'b1; direction = 1'b1; speed = 8'd16;
      run_frame("s16a"); chk_x("s16a x0", 0, 1);
      run_frame("s16b"); chk_x("s16b x0", 0, 2);
      run_frame("s16c"); chk_x("s16c x0", 0, 3);
      speed = 8'd8;
      run_frame("s8a"); chk_x("s8a x0", 0, 3);
      run_frame("s8b"); chk_x("s8b x0", 0, 4);
      run_frame("s8c"); chk_x("s8c x0", 0, 4);
      run_frame("s8d"); chk_x("s8d x0", 0, 5);
      speed = 8'd24;
      run_frame("s24a"); chk_x("s24a x0", 0, 6);
      run_frame("s24b"); chk_x("s24b x0", 0, 8);
      run_frame("s24c"); chk_x("s24c x0", 0, 9);
      run_frame("s24d"); chk_x("s24d x0", 0, 11);

      // hazard collision, edge touch, wrong row
      do_reset(8'd80);
      enable = 1'b0; frog_y = COORD_W'(ROW);
      frog_x = 11'd130; run_frame("hit1");
      chk("hit1 coll", 32'(collide_h), 32'd1);
      chk("hit1 idx",  32'(coll_idx_h), 32'd1);
      frog_x = 11'd160; run_frame("edge");
      chk("edge coll", 32'(collide_h), 32'd0);
      frog_x = 11'd130; frog_y = COORD_W'(ROW + 1); run_frame("row");
      chk("row coll", 32'(collide_h), 32'd0);

      // two overlapping objects: lowest index wins, mask moves it
      num_obj = 4'd8;
      do_reset(8'd0);
      frog_x = 11'd20; frog_y = COORD_W'(ROW);
      run_frame("prio0"); chk("prio0 idx", 32'(coll_idx_h), 32'd0);
      obj_mask = 8'hFE;
      run_frame("prio1"); chk("prio1 idx", 32'(coll_idx_h), 32'd1);

      // carrier moving left on obj2, then mask it away
      num_obj = 4'd4; obj_mask = 8'hFF;
      do_reset(8'd80);
      direction = 1'b0; speed = 8'd32; enable = 1'b1; frog_x = 11'd245;
      run_frame("carry");
      chk("carry coll", 32'(collide_c), 32'd1);
      chk("carry idx",  32'(coll_idx_c), 32'd2);
      chk("carry dx",   32'(carry_c), 32'h7FE);
      obj_mask = 8'hFB;
      run_frame("unmask"); chk("unmask coll", 32'(collide_c), 32'd0);

      // num_obj above MAX_OBJ is clamped
      num_obj = 4'd12; obj_mask = 8'hA5;
      run_frame("clamp"); chk("clamp valid", 32'(obj_valid_h), 32'hA5);

      // wrap both ways across the span boundary
      num_obj = 4'd8; obj_mask = 8'hFF; frog_y = '0;
      do_reset(8'd173);
      chk_x("wrap pre", 3, 639);
      direction = 1'b1; speed = 8'd16; enable = 1'b1;
      run_frame("wrapR"); chk_x("wrapR x3", 3, -40);
      direction = 1'b0;
      run_frame("wrapL"); chk_x("wrapL x3", 3, 639);

      // freeze holds positions and the accumulator
      direction = 1'b1; speed = 8'd8;
      run_frame("frz0"); chk_x("frz0 x0", 0, 0);
      enable = 1'b0;
      for (int k = 0; k < 10; k++) run_frame($sformatf("frz%0d", k + 1));
      chk_x("frz x0", 0, 0);
      enable = 1'b1;
      run_frame("thaw"); chk_x("thaw x0", 0, 1);

      // random traffic
      row_y = COORD_W'(ROW);
      for (int k = 0; k < 40; k++) begin
         speed     = 8'($urandom_range(0, 255));
         direction = 1'($urandom_range(0, 1));
         enable    = ($urandom_range(0, 3) != 0);
         num_obj   = 4'($urandom_range(0, 15));
         obj_mask  = 8'($urandom_range(0, 255));
         frog_x    = 11'($urandom_range(0, 639));
         frog_y    = ($urandom_range(0, 3) != 0) ? COORD_W'(ROW) : COORD_W'(ROW + 40);
         run_frame($sformatf("rnd%0d", k));
      end

      // reset mid-run while colliding, and mid-sweep
      num_obj = 4'd4; obj_mask = 8'hFF;
      do_reset(8'd80);
      enable = 1'b1; speed = 8'd16; direction = 1'b1;
      frog_x = 11'd130; frog_y = COORD_W'(ROW);
      run_frame("prerst"); chk("prerst coll", 32'(collide_h), 32'd1);
      do_reset(8'd80);
      Reset = 1'b1; @(posedge clk); #1; Reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      do_reset(8'd80);
      run_frame("post");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
